// File: rtl/divmmc_spi_pkg.sv
// rtl/divmmc_spi_pkg.sv - shared DivMMC SPI constants and state encoding
package divmmc_spi_pkg;

    localparam logic [7:0] DIVMMC_PORT_CS   = 8'hE7;
    localparam logic [7:0] DIVMMC_PORT_DATA = 8'hEB;

    localparam logic CS_RESET_DEF  = 1'b1;
    localparam logic IDLE_MOSI_DEF = 1'b1;

    localparam int         XFER_TICKS = 16;
    localparam logic [7:0] RD_FILL    = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } spi_state_e;

endpackage

// File: rtl/divmmc_spi.sv
// rtl/divmmc_spi.sv - DivMMC byte-wide SPI mode-0 master
module divmmc_spi
    import divmmc_spi_pkg::*;
#(
    parameter logic CS_RESET  = CS_RESET_DEF,
    parameter logic IDLE_MOSI = IDLE_MOSI_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       wrCs,
    input  logic       wrData,
    input  logic       rdData,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       busy,
    output logic       spiCs,
    output logic       spiCk,
    output logic       spiMosi,
    input  logic       spiMiso
);

    localparam logic [3:0] LAST_TICK = 4'(XFER_TICKS - 1);

    spi_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] q_q, q_d;
    logic       ck_q, ck_d;
    logic       mosi_q, mosi_d;
    logic       cs_q, cs_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            tx_q    <= RD_FILL;
            rx_q    <= 8'h00;
            q_q     <= 8'hFF;
            ck_q    <= 1'b0;
            mosi_q  <= IDLE_MOSI;
            cs_q    <= CS_RESET;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            q_q     <= q_d;
            ck_q    <= ck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        q_d     = q_q;
        ck_d    = ck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        cs_d    = wrCs ? d[0] : cs_q;

        case (state_q)
            ST_IDLE: begin
                if (wrData || rdData) begin
                    tx_d    = wrData ? d : RD_FILL;
                    mosi_d  = tx_d[7];
                    busy_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (ce) begin
                    cnt_d = cnt_q + 4'd1;
                    if (!ck_q) begin
                        // rising edge: sample MISO
                        ck_d = 1'b1;
                        rx_d = {rx_q[6:0], spiMiso};
                    end else begin
                        ck_d   = 1'b0;
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                        if (cnt_q == LAST_TICK) begin
                            q_d     = rx_q;
                            busy_d  = 1'b0;
                            mosi_d  = IDLE_MOSI;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign q       = q_q;
    assign busy    = busy_q;
    assign spiCs   = cs_q;
    assign spiCk   = ck_q;
    assign spiMosi = mosi_q;

endmodule

// File: tb/tb_divmmc_spi.sv
// tb/tb_divmmc_spi.sv - randomized self-checking bench for divmmc_spi
module tb_divmmc_spi;

    logic       clock = 1'b0;
    logic       reset;
    logic       ce;
    logic       wrCs;
    logic       wrData;
    logic       rdData;
    logic [7:0] d;
    logic [7:0] q;
    logic       busy;
    logic       spiCs;
    logic       spiCk;
    logic       spiMosi;
    logic       spiMiso;

    divmmc_spi dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .wrCs    (wrCs),
        .wrData  (wrData),
        .rdData  (rdData),
        .d       (d),
        .q       (q),
        .busy    (busy),
        .spiCs   (spiCs),
        .spiCk   (spiCk),
        .spiMosi (spiMosi),
        .spiMiso (spiMiso)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ce_per = 1;

    // ce pattern: high one clock in every ce_per
    always @(posedge clock) begin
        cyc = cyc + 1;
        #1 ce = ((cyc % ce_per) == 0);
    end

    // card-side model: captures MOSI and shifts the response byte at each rising SCK
    logic       loop_en;
    logic [7:0] resp_sh;
    logic [7:0] cap;
    int         rise_cnt;
    logic [7:0] exp_q;

    always @(posedge spiCk) begin
        cap      = {cap[6:0], spiMosi};
        resp_sh  = {resp_sh[6:0], 1'b1};
        rise_cnt = rise_cnt + 1;
    end

    assign spiMiso = loop_en ? spiMosi : resp_sh[7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cs"},   spiCs,   1'b1);
        chk({tag, "_ck"},   spiCk,   1'b0);
        chk({tag, "_mosi"}, spiMosi, 1'b1);
        chk({tag, "_busy"}, busy,    1'b0);
        chk({tag, "_q"},    q,       8'hFF);
    endtask

    task automatic write_cs(input logic v);
        wrCs = 1'b1;
        d    = {7'h55, v};
        @(negedge clock);
        wrCs = 1'b0;
        chk("cs_write", spiCs, v);
    endtask

    // Called at a negedge; returns at the negedge where busy is first seen low.
    task automatic run_xfer(input bit is_rd, input logic [7:0] byt, input logic [7:0] resp,
                            input bit lb, input bit poke);
        logic [7:0] exp_tx;
        int ticks;
        int bcyc;
        exp_tx   = is_rd ? 8'hFF : byt;
        loop_en  = lb;
        resp_sh  = resp;
        cap      = 8'h00;
        rise_cnt = 0;
        d        = byt;
        wrData   = !is_rd;
        rdData   = is_rd;
        @(negedge clock);
        wrData = 1'b0;
        rdData = 1'b0;
        chk("busy_rise",  busy,    1'b1);
        chk("q_hold",     q,       exp_q);
        chk("mosi_first", spiMosi, exp_tx[7]);
        ticks = 0;
        bcyc  = 0;
        while (busy && bcyc < 400) begin
            if (ce) ticks++;
            bcyc++;
            if (poke && bcyc == 3) begin
                d      = ~byt;
                wrData = 1'b1;
                rdData = 1'b1;
            end else begin
                wrData = 1'b0;
                rdData = 1'b0;
            end
            @(negedge clock);
        end
        wrData = 1'b0;
        rdData = 1'b0;
        if (bcyc >= 400) chk("timeout", 1'b1, 1'b0);
        exp_q = lb ? exp_tx : resp;
        chk("ce_ticks",  ticks,    16);
        chk("ck_rises",  rise_cnt, 8);
        chk("mosi_bits", cap,      exp_tx);
        chk("q_end",     q,        exp_q);
        chk("ck_idle",   spiCk,    1'b0);
        chk("mosi_idle", spiMosi,  1'b1);
        chk("busy_len",  (bcyc >= 15 * ce_per + 1) && (bcyc <= 16 * ce_per), 1'b1);
    endtask

    task automatic reset_mid_xfer();
        int ticks;
        int guard;
        loop_en  = 1'b1;
        cap      = 8'h00;
        rise_cnt = 0;
        d        = 8'hC7;
        wrData   = 1'b1;
        @(negedge clock);
        wrData = 1'b0;
        ticks  = 0;
        guard  = 0;
        while (ticks < 5 && guard < 400) begin
            if (ce) ticks++;
            guard++;
            if (ticks < 5) @(negedge clock);
        end
        if (guard >= 400) chk("rst_timeout", 1'b1, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clock);
        reset = 1'b0;
        exp_q = 8'hFF;
        @(negedge clock);
        check_reset_outputs("rst_after");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        ce       = 1'b1;
        wrCs     = 1'b0;
        wrData   = 1'b0;
        rdData   = 1'b0;
        d        = 8'h00;
        loop_en  = 1'b0;
        resp_sh  = 8'hFF;
        cap      = 8'h00;
        rise_cnt = 0;
        exp_q    = 8'hFF;
        repeat (3) @(negedge clock);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        repeat (100) @(negedge clock);
        check_reset_outputs("idle");

        write_cs(1'b0);
        ce_per = 1;
        run_xfer(1'b0, 8'hA5, 8'h00, 1'b1, 1'b0);
        run_xfer(1'b1, 8'h00, 8'h3C, 1'b0, 1'b0);
        run_xfer(1'b1, 8'h00, 8'h96, 1'b0, 1'b0);

        ce_per = 4;
        @(negedge clock);
        run_xfer(1'b0, 8'h5A, 8'h00, 1'b1, 1'b0);

        ce_per = 2;
        @(negedge clock);
        run_xfer(1'b0, 8'h11, 8'h00, 1'b1, 1'b1);
        run_xfer(1'b0, 8'h22, 8'h00, 1'b1, 1'b0);

        ce_per = 1;
        @(negedge clock);
        reset_mid_xfer();
        write_cs(1'b0);
        run_xfer(1'b0, 8'h69, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ce_per = $urandom_range(1, 3);
            @(negedge clock);
            if ($urandom_range(0, 4) == 0) write_cs($urandom_range(0, 1));
            run_xfer($urandom_range(0, 1), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 1), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
